// File: rtl/pipelined_fiber_merger_pkg.sv
// Shared defaults and helpers for the radix-N fiber merger.
//   DEF_RADIX       : default number of input lanes
//   DEF_COORD_BITS  : default unsigned coordinate width
//   DEF_MERGE_DUPS  : default tie handling (1 = collapse equal coordinates)
//   tree_levels()   : depth of the min-compare tree for a given radix
package pipelined_fiber_merger_pkg;

  localparam int unsigned DEF_RADIX      = 4;
  localparam int unsigned DEF_COORD_BITS = 8;
  localparam int unsigned DEF_MERGE_DUPS = 1;

  // Number of tree levels; never zero so index vectors stay at least 1 bit wide.
  function automatic int unsigned tree_levels(input int unsigned radix);
    return (radix > 1) ? $clog2(radix) : 1;
  endfunction

endpackage

// File: rtl/pipelined_fiber_merger_min_tree.sv
// Combinational minimum finder over the eligible lanes of the merger.
//   coords     : lane i coordinate at bits [i*COORD_BITS +: COORD_BITS]
//   valid_mask : lanes taking part in the comparison
//   min_coord  : unsigned minimum over eligible lanes (0 if none eligible)
//   pick       : lanes to pop; all tied lanes when MERGE_DUPS=1, else lowest index
module pipelined_fiber_merger_min_tree
  import pipelined_fiber_merger_pkg::*;
#(
  parameter int unsigned RADIX      = DEF_RADIX,
  parameter int unsigned COORD_BITS = DEF_COORD_BITS,
  parameter int unsigned MERGE_DUPS = DEF_MERGE_DUPS
) (
  input  logic [RADIX*COORD_BITS-1:0] coords,
  input  logic [RADIX-1:0]            valid_mask,
  output logic [COORD_BITS-1:0]       min_coord,
  output logic [RADIX-1:0]            pick
);

  localparam int unsigned LW = tree_levels(RADIX);
  localparam int unsigned P  = 1 << LW;

  // Heap-ordered binary tree: leaves at [P, 2P), root at 1. Left wins ties,
  // which gives the lowest-index winner at the root.
  always_comb begin : reduce_tree
    logic [COORD_BITS-1:0] node_c [2*P];
    logic                  node_v [2*P];
    logic [LW-1:0]         node_i [2*P];
    logic                  take_l;

    take_l = 1'b0;
    for (int unsigned n = 0; n < 2*P; n++) begin
      node_c[n] = '0;
      node_v[n] = 1'b0;
      node_i[n] = '0;
    end
    for (int unsigned i = 0; i < RADIX; i++) begin
      node_c[P+i] = coords[i*COORD_BITS +: COORD_BITS];
      node_v[P+i] = valid_mask[i];
      node_i[P+i] = LW'(i);
    end
    for (int unsigned n = P - 1; n >= 1; n--) begin
      take_l    = node_v[2*n] && (!node_v[2*n+1] || (node_c[2*n] <= node_c[2*n+1]));
      node_c[n] = take_l ? node_c[2*n] : node_c[2*n+1];
      node_i[n] = take_l ? node_i[2*n] : node_i[2*n+1];
      node_v[n] = node_v[2*n] || node_v[2*n+1];
    end

    min_coord = node_v[1] ? node_c[1] : '0;
    pick      = '0;
    for (int unsigned i = 0; i < RADIX; i++) begin
      if (MERGE_DUPS != 0) begin
        pick[i] = node_v[1] && valid_mask[i] &&
                  (coords[i*COORD_BITS +: COORD_BITS] == node_c[1]);
      end else begin
        pick[i] = node_v[1] && (node_i[1] == LW'(i));
      end
    end
  end

endmodule

// File: rtl/pipelined_fiber_merger.sv
// Radix-N sorted-fiber merger with a registered output stage.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   in_valid/in_coord/in_last/in_ready : per-lane sorted coordinate streams
//   out_valid/out_coord/out_lane_mask/out_last/out_ready : merged ascending stream
// Lanes that delivered their last token sit out until every lane has finished
// the current fiber; the beat that completes the fiber clears all done flags.
module pipelined_fiber_merger
  import pipelined_fiber_merger_pkg::*;
#(
  parameter int unsigned MERGER_RADIX      = DEF_RADIX,
  parameter int unsigned MERGER_COORD_BITS = DEF_COORD_BITS,
  parameter int unsigned MERGE_DUPS        = DEF_MERGE_DUPS
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [MERGER_RADIX-1:0]                in_valid,
  input  logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] in_coord,
  input  logic [MERGER_RADIX-1:0]                in_last,
  output logic [MERGER_RADIX-1:0]                in_ready,
  output logic                                   out_valid,
  output logic [MERGER_COORD_BITS-1:0]           out_coord,
  output logic [MERGER_RADIX-1:0]                out_lane_mask,
  output logic                                   out_last,
  input  logic                                   out_ready
);

  localparam int unsigned R = MERGER_RADIX;
  localparam int unsigned C = MERGER_COORD_BITS;

  logic [R-1:0] done_q, done_d;
  logic         out_valid_q, out_valid_d;
  logic [C-1:0] out_coord_q, out_coord_d;
  logic [R-1:0] out_lane_mask_q, out_lane_mask_d;
  logic         out_last_q, out_last_d;

  logic [R-1:0] cmp_mask_c, pick_c, term_c;
  logic [C-1:0] min_c;
  logic         decide_c, load_c, fiber_end_c;

  pipelined_fiber_merger_min_tree #(
    .RADIX      (R),
    .COORD_BITS (C),
    .MERGE_DUPS (MERGE_DUPS)
  ) u_min_tree (
    .coords     (in_coord),
    .valid_mask (cmp_mask_c),
    .min_coord  (min_c),
    .pick       (pick_c)
  );

  // Handshake, done tracking and next-state of the output register.
  always_comb begin
    cmp_mask_c  = in_valid & ~done_q;
    // Only decide once every undone lane presents a token: no speculative emit.
    decide_c    = (~done_q != '0) && ((in_valid | done_q) == '1);
    load_c      = decide_c && (!out_valid_q || out_ready) && !reset;
    in_ready    = pick_c & {R{load_c}};
    term_c      = done_q | (pick_c & in_last);
    fiber_end_c = &term_c;

    done_d          = done_q;
    out_valid_d     = out_valid_q;
    out_coord_d     = out_coord_q;
    out_lane_mask_d = out_lane_mask_q;
    out_last_d      = out_last_q;

    if (load_c) begin
      out_valid_d     = 1'b1;
      out_coord_d     = min_c;
      out_lane_mask_d = pick_c;
      out_last_d      = fiber_end_c;
      // Closing beat of a fiber re-arms every lane for the next one.
      done_d          = fiber_end_c ? '0 : term_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_q          <= '0;
      out_valid_q     <= 1'b0;
      out_coord_q     <= '0;
      out_lane_mask_q <= '0;
      out_last_q      <= 1'b0;
    end else begin
      done_q          <= done_d;
      out_valid_q     <= out_valid_d;
      out_coord_q     <= out_coord_d;
      out_lane_mask_q <= out_lane_mask_d;
      out_last_q      <= out_last_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_coord     = out_coord_q;
  assign out_lane_mask = out_lane_mask_q;
  assign out_last      = out_last_q;

endmodule
